// File: rtl/pcie_phy_pkg.sv
// Shared symbol codes, CONTROL encoding and sequencer state for the PCIe PHY transmit path.
package pcie_phy_pkg;

    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_SDP = 8'h5C;
    localparam logic [7:0] SYM_END = 8'hFD;
    localparam logic [7:0] SYM_EDB = 8'hFE;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_IDL = 8'h7C;
    localparam logic [7:0] SYM_COM = 8'hBC;

    localparam logic [1:0] CTRL_DATA  = 2'b00;
    localparam logic [1:0] CTRL_FRAME = 2'b01;
    localparam logic [1:0] CTRL_OS    = 2'b10;
    localparam logic [1:0] CTRL_COM   = 2'b11;

    localparam int unsigned OS_CNT_W  = 2;
    localparam int unsigned SKP_CNT_W = 16;
    localparam logic [OS_CNT_W-1:0] OS_LAST = OS_CNT_W'(2);

    typedef enum logic [2:0] {
        S_COM,
        S_OS,
        S_START,
        S_DATA,
        S_END
    } tx_state_e;

    // One captured upstream byte with its qualifiers.
    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       bad;
    } pkt_beat_t;

endpackage

// File: rtl/phy_skp_timer.sv
// SKP interval timer: raises skp_pending SKP_INTERVAL-1 cycles after the last clear and holds it.
module phy_skp_timer
    import pcie_phy_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic skp_clear,
    output logic skp_pending
);

    localparam logic [SKP_CNT_W-1:0] CNT_TERM = SKP_CNT_W'(SKP_INTERVAL - 1);

    logic [SKP_CNT_W-1:0] cnt_q, cnt_d;
    logic                 pending_q, pending_d;

    // Clear has priority over a coincident set.
    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        if (skp_clear) begin
            cnt_d     = '0;
            pending_d = 1'b0;
        end else begin
            if (cnt_q != CNT_TERM) begin
                cnt_d = SKP_CNT_W'(cnt_q + SKP_CNT_W'(1));
            end
            pending_d = pending_q | (cnt_d == CNT_TERM);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign skp_pending = pending_q;

endmodule

// File: rtl/phy_tx_scheduler.sv
// PCIe PHY transmit sequencer: frames packets with STP/SDP..END/EDB, fills idle with COM+IDL
// and inserts COM+SKP at ordered-set boundaries when the SKP timer requests it.
module phy_tx_scheduler
    import pcie_phy_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PKT_VALID,
    input  logic [7:0] PKT_DATA,
    input  logic       PKT_LAST,
    input  logic       PKT_SDP,
    input  logic       PKT_BAD,
    output logic       PKT_READY,
    output logic [7:0] D,
    output logic [7:0] START_END,
    output logic [7:0] ORDERED_SET,
    output logic [7:0] LOG_COM,
    output logic [1:0] CONTROL,
    output logic       UNDERRUN
);

    tx_state_e             state_q, state_d;
    logic [OS_CNT_W-1:0]   os_cnt_q, os_cnt_d;
    logic                  os_skp_q, os_skp_d;
    logic                  sdp_q, sdp_d;
    logic                  edb_q, edb_d;
    pkt_beat_t             beat_q, beat_d;
    logic                  skp_pending;
    logic                  skp_clear;

    phy_skp_timer #(
        .SKP_INTERVAL (SKP_INTERVAL)
    ) u_skp_timer (
        .CLK         (CLK),
        .RESET       (RESET),
        .skp_clear   (skp_clear),
        .skp_pending (skp_pending)
    );

    // Next-state: packets start only at the end of an ordered set, SKP takes priority.
    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        os_skp_d  = os_skp_q;
        sdp_d     = sdp_q;
        edb_d     = edb_q;
        beat_d    = beat_q;
        skp_clear = 1'b0;
        case (state_q)
            S_COM: begin
                state_d  = S_OS;
                os_cnt_d = '0;
            end
            S_OS: begin
                os_cnt_d = OS_CNT_W'(os_cnt_q + OS_CNT_W'(1));
                if (os_cnt_q == OS_LAST) begin
                    if (skp_pending) begin
                        state_d   = S_COM;
                        os_skp_d  = 1'b1;
                        skp_clear = 1'b1;
                    end else if (PKT_VALID) begin
                        state_d = S_START;
                        sdp_d   = PKT_SDP;
                    end else begin
                        state_d  = S_COM;
                        os_skp_d = 1'b0;
                    end
                end
            end
            S_START: begin
                if (PKT_VALID) begin
                    beat_d  = '{data: PKT_DATA, last: PKT_LAST, bad: PKT_BAD};
                    state_d = S_DATA;
                end else begin
                    state_d = S_END;
                    edb_d   = 1'b1;
                end
            end
            S_DATA: begin
                if (beat_q.last) begin
                    state_d = S_END;
                    edb_d   = beat_q.bad;
                end else if (PKT_VALID) begin
                    beat_d = '{data: PKT_DATA, last: PKT_LAST, bad: PKT_BAD};
                end else begin
                    state_d = S_END;
                    edb_d   = 1'b1;
                end
            end
            S_END: begin
                state_d   = S_COM;
                os_skp_d  = skp_pending;
                skp_clear = skp_pending;
            end
            default: begin
                state_d  = S_COM;
                os_skp_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_COM;
            os_cnt_q <= '0;
            os_skp_q <= 1'b0;
            sdp_q    <= 1'b0;
            edb_q    <= 1'b0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            os_cnt_q <= os_cnt_d;
            os_skp_q <= os_skp_d;
            sdp_q    <= sdp_d;
            edb_q    <= edb_d;
            beat_q   <= beat_d;
        end
    end

    // Symbol outputs decoded from the registered state only.
    always_comb begin
        D           = 8'h00;
        START_END   = 8'h00;
        ORDERED_SET = 8'h00;
        LOG_COM     = 8'h00;
        CONTROL     = CTRL_COM;
        PKT_READY   = 1'b0;
        case (state_q)
            S_COM: begin
                CONTROL = CTRL_COM;
                LOG_COM = SYM_COM;
            end
            S_OS: begin
                CONTROL     = CTRL_OS;
                ORDERED_SET = os_skp_q ? SYM_SKP : SYM_IDL;
            end
            S_START: begin
                CONTROL   = CTRL_FRAME;
                START_END = sdp_q ? SYM_SDP : SYM_STP;
                PKT_READY = 1'b1;
            end
            S_DATA: begin
                CONTROL   = CTRL_DATA;
                D         = beat_q.data;
                PKT_READY = ~beat_q.last;
            end
            S_END: begin
                CONTROL   = CTRL_FRAME;
                START_END = edb_q ? SYM_EDB : SYM_END;
            end
            default: begin
                CONTROL = CTRL_COM;
                LOG_COM = SYM_COM;
            end
        endcase
    end

    // Underrun is flagged in the very cycle the source fails to supply a requested byte.
    assign UNDERRUN = PKT_READY & ~PKT_VALID;

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Bench for phy_tx_scheduler: packet-level reference model expands each decision into the
// full expected symbol stream; scenario tasks compare the recorded DUT stream against it.
module tb_phy_tx_scheduler;

    localparam int SKP_INTERVAL = 16;

    logic       CLK;
    logic       RESET;
    logic       PKT_VALID;
    logic [7:0] PKT_DATA;
    logic       PKT_LAST;
    logic       PKT_SDP;
    logic       PKT_BAD;
    logic       PKT_READY;
    logic [7:0] D;
    logic [7:0] START_END;
    logic [7:0] ORDERED_SET;
    logic [7:0] LOG_COM;
    logic [1:0] CONTROL;
    logic       UNDERRUN;

    phy_tx_scheduler #(.SKP_INTERVAL(SKP_INTERVAL)) dut (
        .CLK(CLK), .RESET(RESET), .PKT_VALID(PKT_VALID), .PKT_DATA(PKT_DATA),
        .PKT_LAST(PKT_LAST), .PKT_SDP(PKT_SDP), .PKT_BAD(PKT_BAD), .PKT_READY(PKT_READY),
        .D(D), .START_END(START_END), .ORDERED_SET(ORDERED_SET), .LOG_COM(LOG_COM),
        .CONTROL(CONTROL), .UNDERRUN(UNDERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] ctrl;
        logic [7:0] d;
        logic [7:0] se;
        logic [7:0] os;
        logic [7:0] com;
        logic       rdy;
        logic       unr;
    } obs_t;

    int errors = 0;
    int checks = 0;

    // Current packet as presented by the source.
    logic [7:0] cur_bytes [64];
    int         cur_len;
    int         cur_k;
    bit         cur_sdp;
    bit         cur_bad;

    obs_t exp_q[$];
    obs_t obs_log[$];
    obs_t exp_log[$];
    int   age;

    function automatic obs_t mk(logic [1:0] ctrl, logic [7:0] sym, logic rdy, logic unr);
        obs_t o;
        o = '0;
        o.ctrl = ctrl;
        o.rdy  = rdy;
        o.unr  = unr;
        case (ctrl)
            2'b00:   o.d   = sym;
            2'b01:   o.se  = sym;
            2'b10:   o.os  = sym;
            default: o.com = sym;
        endcase
        return o;
    endfunction

    function automatic void push_os(bit skp);
        exp_q.push_back(mk(2'b11, 8'hBC, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(2'b10, skp ? 8'h1C : 8'h7C, 1'b0, 1'b0));
    endfunction

    // Whole packet: start, one data symbol per accepted byte, end (EDB if truncated or bad).
    function automatic void push_pkt();
        bit complete;
        complete = (cur_k == cur_len);
        exp_q.push_back(mk(2'b01, cur_sdp ? 8'h5C : 8'hFB, 1'b1, cur_k == 0));
        for (int i = 0; i < cur_k; i++)
            exp_q.push_back(mk(2'b00, cur_bytes[i], !(complete && i == cur_len - 1),
                               !complete && i == cur_k - 1));
        exp_q.push_back(mk(2'b01, (!complete || cur_bad) ? 8'hFE : 8'hFD, 1'b0, 1'b0));
    endfunction

    always @(posedge CLK or posedge RESET) begin
        obs_t popped;
        bit   pending;
        bit   new_skp;
        if (RESET) begin
            exp_q.delete();
            push_os(1'b0);
            age = 0;
        end else begin
            popped  = exp_q.pop_front();
            pending = (age >= SKP_INTERVAL - 1);
            new_skp = 1'b0;
            if (exp_q.size() == 0) begin
                if (pending) begin
                    push_os(1'b1);
                    new_skp = 1'b1;
                end else if (popped.ctrl == 2'b10 && PKT_VALID) begin
                    push_pkt();
                end else begin
                    push_os(1'b0);
                end
            end
            age = new_skp ? 0 : age + 1;
        end
    end

    always @(negedge CLK) begin
        if (!RESET) begin
            obs_log.push_back({CONTROL, D, START_END, ORDERED_SET, LOG_COM, PKT_READY, UNDERRUN});
            exp_log.push_back(exp_q[0]);
        end
    end

    function automatic int find_start(int from);
        for (int i = from; i < obs_log.size(); i++)
            if (obs_log[i].ctrl == 2'b01) return i;
        return -1;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        PKT_VALID = 1'b0;
        idle(2);
        RESET = 1'b0;
        obs_log.delete();
        exp_log.delete();
    endtask

    // Source: holds VALID until cur_k bytes are taken; then ends on completion or underrun.
    task automatic send_pkt(input int len, input int k, input bit sdp, input bit bad, output bit ok);
        int idx;
        bit done;
        idx = 0;
        done = 1'b0;
        cur_len = len; cur_k = k; cur_sdp = sdp; cur_bad = bad;
        for (int budget = 0; budget < 400 && !done; budget++) begin
            PKT_VALID = (idx < k);
            PKT_DATA  = cur_bytes[idx];
            PKT_LAST  = (idx == len - 1);
            PKT_SDP   = sdp;
            PKT_BAD   = bad;
            @(negedge CLK);
            if (PKT_VALID && PKT_READY) begin
                idx++;
                if (idx == len) done = 1'b1;
            end else if (!PKT_VALID && PKT_READY) begin
                done = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        PKT_VALID = 1'b0;
        PKT_LAST  = 1'b0;
        PKT_BAD   = 1'b0;
        ok = done;
    endtask

    task automatic test_reset();
        obs_t o;
        RESET = 1'b1;
        PKT_VALID = 1'b0; PKT_DATA = 8'h00; PKT_LAST = 1'b0; PKT_SDP = 1'b0; PKT_BAD = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        o = {CONTROL, D, START_END, ORDERED_SET, LOG_COM, PKT_READY, UNDERRUN};
        checks++;
        if (o !== mk(2'b11, 8'hBC, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_outputs got %h exp %h", o, mk(2'b11, 8'hBC, 1'b0, 1'b0));
        end
        checks++;
        if (UNDERRUN !== 1'b0) begin
            errors++;
            $display("FAIL reset_underrun got %b exp 0", UNDERRUN);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_idle();
        do_reset();
        idle(26);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_log[i].ctrl !== (i == 0 ? 2'b11 : 2'b10) || (i > 0 && obs_log[i].os !== 8'h7C)) begin
                errors++;
                $display("FAIL idle_first_os cyc%0d got %h", i, obs_log[i]);
            end
        end
        checks++;
        if (obs_log[16].com !== 8'hBC) begin
            errors++;
            $display("FAIL idle_skp_com got %h exp BC", obs_log[16].com);
        end
        for (int i = 17; i < 20; i++) begin
            checks++;
            if (obs_log[i].os !== 8'h1C) begin
                errors++;
                $display("FAIL idle_skp cyc%0d got %h exp 1C", i, obs_log[i].os);
            end
        end
        for (int i = 0; i < obs_log.size(); i++) begin
            checks++;
            if (obs_log[i] !== exp_log[i]) begin
                errors++;
                $display("FAIL idle_stream cyc%0d got %h exp %h", i, obs_log[i], exp_log[i]);
            end
        end
    endtask

    task automatic test_packet();
        logic [7:0] want [4];
        bit ok;
        int s;
        want = '{8'h01, 8'h02, 8'h10, 8'h20};
        do_reset();
        idle(2);
        for (int i = 0; i < 4; i++) cur_bytes[i] = want[i];
        send_pkt(4, 4, 1'b0, 1'b0, ok);
        idle(4);
        checks++;
        if (!ok) begin errors++; $display("FAIL packet_timeout got 0 exp 1"); end
        s = find_start(0);
        checks++;
        if (s < 0 || s + 7 > obs_log.size()) begin
            errors++; $display("FAIL packet_no_start got %0d exp >=0", s); return;
        end
        checks++;
        if (obs_log[s].se !== 8'hFB) begin errors++; $display("FAIL packet_stp got %h exp FB", obs_log[s].se); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_log[s+1+i].ctrl !== 2'b00 || obs_log[s+1+i].d !== want[i]) begin
                errors++;
                $display("FAIL packet_data%0d got %h exp %h", i, obs_log[s+1+i].d, want[i]);
            end
        end
        checks++;
        if (obs_log[s+5].se !== 8'hFD) begin errors++; $display("FAIL packet_end got %h exp FD", obs_log[s+5].se); end
        checks++;
        if (obs_log[s+6].ctrl !== 2'b11) begin errors++; $display("FAIL packet_com got %b exp 11", obs_log[s+6].ctrl); end
        for (int i = 0; i < obs_log.size(); i++) begin
            checks++;
            if (obs_log[i] !== exp_log[i]) begin
                errors++;
                $display("FAIL packet_stream cyc%0d got %h exp %h", i, obs_log[i], exp_log[i]);
            end
        end
    endtask

    task automatic test_sdp_bad();
        bit ok;
        int s;
        do_reset();
        idle(1);
        cur_bytes[0] = 8'hAA; cur_bytes[1] = 8'h55;
        send_pkt(2, 2, 1'b1, 1'b1, ok);
        idle(4);
        s = find_start(0);
        checks++;
        if (!ok || s < 0 || s + 4 > obs_log.size()) begin
            errors++; $display("FAIL sdp_no_packet got %0d exp >=0", s); return;
        end
        checks++;
        if (obs_log[s].se !== 8'h5C) begin errors++; $display("FAIL sdp_start got %h exp 5C", obs_log[s].se); end
        checks++;
        if (obs_log[s+3].se !== 8'hFE) begin errors++; $display("FAIL bad_end got %h exp FE", obs_log[s+3].se); end
    endtask

    task automatic test_underrun();
        bit ok;
        int s;
        int pulses;
        do_reset();
        idle(2);
        cur_bytes[0] = 8'h11; cur_bytes[1] = 8'h22; cur_bytes[2] = 8'h33; cur_bytes[3] = 8'h44;
        send_pkt(4, 2, 1'b0, 1'b0, ok);
        idle(4);
        s = find_start(0);
        checks++;
        if (!ok || s < 0 || s + 5 > obs_log.size()) begin
            errors++; $display("FAIL underrun_no_packet got %0d exp >=0", s); return;
        end
        checks++;
        if (obs_log[s+1].d !== 8'h11 || obs_log[s+2].d !== 8'h22 || obs_log[s+3].se !== 8'hFE) begin
            errors++;
            $display("FAIL underrun_seq got %h %h %h exp 11 22 FE", obs_log[s+1].d, obs_log[s+2].d, obs_log[s+3].se);
        end
        pulses = 0;
        foreach (obs_log[i]) pulses += int'(obs_log[i].unr);
        checks++;
        if (pulses != 1 || obs_log[s+2].unr !== 1'b1) begin
            errors++; $display("FAIL underrun_pulse got %0d exp 1", pulses);
        end
        for (int i = 0; i < obs_log.size(); i++) begin
            checks++;
            if (obs_log[i] !== exp_log[i]) begin
                errors++;
                $display("FAIL underrun_stream cyc%0d got %h exp %h", i, obs_log[i], exp_log[i]);
            end
        end
    endtask

    task automatic test_skp_deferral();
        bit ok;
        int s;
        int e;
        do_reset();
        idle(2);
        for (int i = 0; i < 30; i++) cur_bytes[i] = 8'($urandom);
        send_pkt(30, 30, 1'b0, 1'b0, ok);
        idle(26);
        s = find_start(0);
        e = s + 31;
        checks++;
        if (!ok || s < 0 || e + 19 > obs_log.size()) begin
            errors++; $display("FAIL defer_no_packet got %0d exp >=0", s); return;
        end
        for (int i = s; i <= e; i++) begin
            checks++;
            if (obs_log[i].ctrl[1] !== 1'b0) begin
                errors++; $display("FAIL defer_split cyc%0d got %b exp 0x", i, obs_log[i].ctrl);
            end
        end
        checks++;
        if (obs_log[e].se !== 8'hFD || obs_log[e+1].com !== 8'hBC) begin
            errors++; $display("FAIL defer_end got %h %h exp FD BC", obs_log[e].se, obs_log[e+1].com);
        end
        for (int i = 2; i < 5; i++) begin
            checks++;
            if (obs_log[e+i].os !== 8'h1C) begin
                errors++; $display("FAIL defer_skp%0d got %h exp 1C", i, obs_log[e+i].os);
            end
        end
        checks++;
        if (obs_log[e+5].com !== 8'hBC || obs_log[e+6].os !== 8'h7C || obs_log[e+14].os !== 8'h7C) begin
            errors++; $display("FAIL defer_idle got %h %h exp BC 7C", obs_log[e+5].com, obs_log[e+6].os);
        end
        checks++;
        if (obs_log[e+17].com !== 8'hBC || obs_log[e+18].os !== 8'h1C) begin
            errors++; $display("FAIL defer_restart got %h %h exp BC 1C", obs_log[e+17].com, obs_log[e+18].os);
        end
    endtask

    task automatic test_random();
        bit ok;
        int len;
        int k;
        do_reset();
        for (int p = 0; p < 14; p++) begin
            len = int'($urandom_range(1, 20));
            k = len;
            if (len > 1 && $urandom_range(0, 3) == 0) k = int'($urandom_range(1, len - 1));
            for (int i = 0; i < len; i++) cur_bytes[i] = 8'($urandom);
            send_pkt(len, k, 1'($urandom), 1'($urandom), ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL random_timeout pkt%0d got 0 exp 1", p); end
            idle(int'($urandom_range(0, 6)));
        end
        idle(6);
        for (int i = 0; i < obs_log.size(); i++) begin
            checks++;
            if (obs_log[i] !== exp_log[i]) begin
                errors++;
                $display("FAIL random_stream cyc%0d got %h exp %h", i, obs_log[i], exp_log[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        int idx;
        do_reset();
        idle(2);
        for (int i = 0; i < 10; i++) cur_bytes[i] = 8'(i + 8'h40);
        cur_len = 10; cur_k = 10; cur_sdp = 1'b0; cur_bad = 1'b0;
        idx = 0;
        PKT_LAST = 1'b0;
        for (int budget = 0; budget < 40 && idx < 3; budget++) begin
            PKT_VALID = 1'b1;
            PKT_DATA  = cur_bytes[idx];
            @(negedge CLK);
            if (PKT_READY) idx++;
            @(posedge CLK);
            #1;
        end
        checks++;
        if (idx != 3) begin errors++; $display("FAIL midrst_accept got %0d exp 3", idx); end
        #1;
        RESET = 1'b1;
        #1;
        checks++;
        if (CONTROL !== 2'b11 || LOG_COM !== 8'hBC || PKT_READY !== 1'b0 || D !== 8'h00) begin
            errors++;
            $display("FAIL midrst_outputs got %b %h %b %h exp 11 BC 0 00", CONTROL, LOG_COM, PKT_READY, D);
        end
        PKT_VALID = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        obs_log.delete();
        exp_log.delete();
        idle(12);
        for (int i = 0; i < obs_log.size(); i++) begin
            checks++;
            if (obs_log[i] !== exp_log[i] || (i % 4 != 0 && obs_log[i].os !== 8'h7C)) begin
                errors++;
                $display("FAIL midrst_stream cyc%0d got %h exp %h", i, obs_log[i], exp_log[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_packet();
        test_sdp_bad();
        test_underrun();
        test_skp_deferral();
        test_random();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
